aes_host_seq: RTL and testbench



---
 rtl/aes_host_seq.sv | 168 ++++++++++++++++
 tb/tb_aes_host_seq.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_host_seq.sv
// Host-side sequencer for the AES-256 core: streams key and plaintext bytes in,
// pulses start, guards the wait for done with a watchdog and streams ciphertext out.
module aes_host_seq #(
    parameter int DONE_TIMEOUT = 1023
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [255:0] cmd_key,
    input  logic [127:0] cmd_block,
    input  logic         cmd_load_key,
    output logic         ld_key_valid,
    output logic [7:0]   ld_key_byte,
    input  logic         ld_key_ready,
    output logic         ld_state_valid,
    output logic [7:0]   ld_state_byte,
    input  logic         ld_state_ready,
    output logic         start,
    input  logic [127:0] core_state_out,
    input  logic         core_done,
    output logic         ct_valid,
    output logic [7:0]   ct_byte,
    output logic         ct_last,
    input  logic         ct_ready,
    output logic         busy,
    output logic         err_timeout
);

    localparam int WD_W = $clog2(DONE_TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(DONE_TIMEOUT);

    typedef enum logic [2:0] {
        IDLE,
        KEY,
        STATE,
        START,
        WAIT,
        OUT
    } state_t;

    state_t          state;
    logic [255:0]    key_sh;
    logic [127:0]    blk_sh;
    logic [127:0]    ct_sh;
    logic [4:0]      cnt;
    logic [WD_W-1:0] wd_cnt;

    // Byte outputs come straight from the top of each shift register.
    assign ld_key_byte   = key_sh[255:248];
    assign ld_state_byte = blk_sh[127:120];
    assign ct_byte       = ct_sh[127:120];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            key_sh         <= '0;
            blk_sh         <= '0;
            ct_sh          <= '0;
            cnt            <= '0;
            wd_cnt         <= '0;
            cmd_ready      <= 1'b1;
            ld_key_valid   <= 1'b0;
            ld_state_valid <= 1'b0;
            start          <= 1'b0;
            ct_valid       <= 1'b0;
            ct_last        <= 1'b0;
            busy           <= 1'b0;
            err_timeout    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        key_sh      <= cmd_key;
                        blk_sh      <= cmd_block;
                        cnt         <= '0;
                        err_timeout <= 1'b0;
                        cmd_ready   <= 1'b0;
                        busy        <= 1'b1;
                        if (cmd_load_key) begin
                            state        <= KEY;
                            ld_key_valid <= 1'b1;
                        end else begin
                            state          <= STATE;
                            ld_state_valid <= 1'b1;
                        end
                    end
                end

                KEY: begin
                    if (ld_key_ready) begin
                        key_sh <= {key_sh[247:0], 8'h00};
                        if (cnt == 5'd31) begin
                            cnt            <= '0;
                            state          <= STATE;
                            ld_key_valid   <= 1'b0;
                            ld_state_valid <= 1'b1;
                        end else begin
                            cnt <= cnt + 5'd1;
                        end
                    end
                end

                STATE: begin
                    if (ld_state_ready) begin
                        blk_sh <= {blk_sh[119:0], 8'h00};
                        if (cnt == 5'd15) begin
                            cnt            <= '0;
                            state          <= START;
                            ld_state_valid <= 1'b0;
                            start          <= 1'b1;
                        end else begin
                            cnt <= cnt + 5'd1;
                        end
                    end
                end

                START: begin
                    start  <= 1'b0;
                    wd_cnt <= '0;
                    state  <= WAIT;
                end

                // A done arriving on the timeout cycle still counts as success.
                WAIT: begin
                    if (core_done) begin
                        ct_sh    <= core_state_out;
                        wd_cnt   <= '0;
                        cnt      <= '0;
                        ct_valid <= 1'b1;
                        ct_last  <= 1'b0;
                        state    <= OUT;
                    end else if (wd_cnt == WD_MAX) begin
                        wd_cnt      <= '0;
                        err_timeout <= 1'b1;
                        busy        <= 1'b0;
                        cmd_ready   <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end

                OUT: begin
                    if (ct_ready) begin
                        ct_sh <= {ct_sh[119:0], 8'h00};
                        if (cnt == 5'd15) begin
                            cnt       <= '0;
                            ct_valid  <= 1'b0;
                            ct_last   <= 1'b0;
                            busy      <= 1'b0;
                            cmd_ready <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            cnt     <= cnt + 5'd1;
                            ct_last <= (cnt == 5'd14);
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_host_seq.sv
// Directed bench for aes_host_seq: the bench plays the AES core and the
// downstream consumer, with every expected byte written out by hand.
module tb_aes_host_seq;

    logic         clk;
    logic         rst_n;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [255:0] cmd_key;
    logic [127:0] cmd_block;
    logic         cmd_load_key;
    logic         ld_key_valid;
    logic [7:0]   ld_key_byte;
    logic         ld_key_ready;
    logic         ld_state_valid;
    logic [7:0]   ld_state_byte;
    logic         ld_state_ready;
    logic         start;
    logic [127:0] core_state_out;
    logic         core_done;
    logic         ct_valid;
    logic [7:0]   ct_byte;
    logic         ct_last;
    logic         ct_ready;
    logic         busy;
    logic         err_timeout;

    int checks = 0;
    int errors = 0;

    aes_host_seq #(.DONE_TIMEOUT(15)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_key        (cmd_key),
        .cmd_block      (cmd_block),
        .cmd_load_key   (cmd_load_key),
        .ld_key_valid   (ld_key_valid),
        .ld_key_byte    (ld_key_byte),
        .ld_key_ready   (ld_key_ready),
        .ld_state_valid (ld_state_valid),
        .ld_state_byte  (ld_state_byte),
        .ld_state_ready (ld_state_ready),
        .start          (start),
        .core_state_out (core_state_out),
        .core_done      (core_done),
        .ct_valid       (ct_valid),
        .ct_byte        (ct_byte),
        .ct_last        (ct_last),
        .ct_ready       (ct_ready),
        .busy           (busy),
        .err_timeout    (err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput(tag, {cmd_ready, ld_key_valid, ld_state_valid, start, ct_valid, ct_last, busy, err_timeout,
                          ld_key_byte, ld_state_byte, ct_byte},
                    {8'b1000_0000, 24'h000000});
    endtask

    // Wait (bounded) for the sequencer to be idle, then present one command for a single cycle.
    task automatic applyStimulus(input logic [255:0] key, input logic [127:0] blk, input logic load_key);
        int n = 0;
        while (!cmd_ready && n < 100) begin
            tick();
            n++;
        end
        checkOutput("cmd_ready_wait", cmd_ready, 1);
        cmd_key      = key;
        cmd_block    = blk;
        cmd_load_key = load_key;
        cmd_valid    = 1'b1;
        tick();
        cmd_valid = 1'b0;
        cmd_key   = '1;
        cmd_block = '1;
        checkOutput("cmd_accept", {cmd_ready, busy, err_timeout}, 3'b010);
    endtask

    task automatic sendKey(input logic [255:0] key, input bit toggle);
        int xfer = 0;
        int cycles = 0;
        logic rdy = toggle ? 1'b0 : 1'b1;
        while (xfer < 32 && cycles < 200) begin
            checkOutput($sformatf("key_byte%0d", xfer), {ld_state_valid, ld_key_valid, ld_key_byte},
                        {2'b01, key[255 - 8*xfer -: 8]});
            ld_key_ready = rdy;
            tick();
            if (rdy) xfer++;
            if (toggle) rdy = ~rdy;
            cycles++;
        end
        ld_key_ready = 1'b0;
        checkOutput("key_xfer_count", xfer, 32);
    endtask

    task automatic sendState(input logic [127:0] blk);
        for (int i = 0; i < 16; i++) begin
            checkOutput($sformatf("state_byte%0d", i), {ld_key_valid, ld_state_valid, start, ld_state_byte},
                        {3'b010, blk[127 - 8*i -: 8]});
            ld_state_ready = 1'b1;
            tick();
        end
        ld_state_ready = 1'b0;
    endtask

    // Acts as the core: answer start with a done pulse after `delay` further WAIT cycles.
    task automatic finishCore(input logic [127:0] ct, input int delay);
        checkOutput("start_pulse", {start, ld_key_valid, ld_state_valid, busy}, 4'b1001);
        tick();
        for (int i = 0; i < delay; i++) begin
            checkOutput($sformatf("wait%0d", i), {start, ct_valid, busy, err_timeout}, 4'b0010);
            tick();
        end
        core_state_out = ct;
        core_done      = 1'b1;
        tick();
        core_done      = 1'b0;
        core_state_out = ~ct;
    endtask

    task automatic drainCt(input logic [127:0] ct, input int stallAt, input int stallLen);
        int got = 0;
        int stalled = 0;
        int cycles = 0;
        while (got < 16 && cycles < 100) begin
            checkOutput($sformatf("ct_byte%0d", got), {ct_valid, ct_last, cmd_ready, err_timeout, ct_byte},
                        {1'b1, (got == 15), 2'b00, ct[127 - 8*got -: 8]});
            if (got == stallAt && stalled < stallLen) begin
                ct_ready = 1'b0;
                stalled++;
            end else begin
                ct_ready = 1'b1;
            end
            tick();
            if (ct_ready) got++;
            cycles++;
        end
        ct_ready = 1'b1;
        checkOutput("ct_count", got, 16);
        checkOutput("ct_done_idle", {ct_valid, ct_last, busy, cmd_ready}, 4'b0001);
    endtask

    logic [255:0] key1  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    logic [127:0] pt1   = 128'h00112233445566778899aabbccddeeff;
    logic [127:0] ct1   = 128'h8ea2b7ca516745bfeafc49904b496089;
    logic [255:0] key2  = 256'hf0e1d2c3b4a5968778695a4b3c2d1e0f_0123456789abcdeffedcba9876543210;
    logic [127:0] pt2   = 128'h3243f6a8885a308d313198a2e0370734;
    logic [127:0] ct2   = 128'h5a5aa5a5_0f0f_f0f0_1234_5678_9abc_def0;
    logic [255:0] key6  = 256'hdeadbeef_cafef00d_11223344_55667788_99aabbcc_ddeeff00_a1b2c3d4_e5f60718;
    logic [255:0] key7  = 256'h7766554433221100_8899aabbccddeeff_0f1e2d3c4b5a6978_8796a5b4c3d2e1f0;

    initial begin
        rst_n          = 1'b0;
        cmd_valid      = 1'b0;
        cmd_key        = '0;
        cmd_block      = '0;
        cmd_load_key   = 1'b0;
        ld_key_ready   = 1'b0;
        ld_state_ready = 1'b0;
        core_state_out = '0;
        core_done      = 1'b0;
        ct_ready       = 1'b1;

        tick();
        tick();
        checkResetOutputs("reset_values");
        rst_n = 1'b1;
        tick();
        checkResetOutputs("after_release");

        $display("[TB] test 1: FIPS-197 C.3 vector");
        applyStimulus(key1, pt1, 1'b1);
        sendKey(key1, 1'b0);
        sendState(pt1);
        finishCore(ct1, 3);
        drainCt(ct1, 99, 0);

        $display("[TB] test 2: key ready toggling");
        applyStimulus(key2, pt2, 1'b1);
        sendKey(key2, 1'b1);
        sendState(pt2);
        finishCore(ct2, 0);
        drainCt(ct2, 99, 0);

        $display("[TB] test 3: ct stall, done on the timeout cycle");
        applyStimulus(key1, pt2, 1'b1);
        sendKey(key1, 1'b0);
        sendState(pt2);
        finishCore(ct1, 15);
        drainCt(ct1, 3, 5);

        $display("[TB] test 4: key phase skipped");
        applyStimulus(key2, pt1, 1'b0);
        sendState(pt1);
        finishCore(ct2, 1);
        drainCt(ct2, 99, 0);

        $display("[TB] test 5: watchdog timeout");
        applyStimulus(key2, pt1, 1'b0);
        sendState(pt1);
        checkOutput("t5_start", {start, busy}, 2'b11);
        tick();
        for (int w = 0; w < 16; w++) begin
            checkOutput($sformatf("t5_wait%0d", w), {busy, err_timeout, ct_valid, cmd_ready}, 4'b1000);
            tick();
        end
        checkOutput("t5_timeout", {err_timeout, busy, cmd_ready, ct_valid}, 4'b1010);
        tick();
        tick();
        checkOutput("t5_sticky", {err_timeout, ct_valid, cmd_ready}, 3'b101);

        $display("[TB] test 6: reset mid key stream");
        applyStimulus(key6, pt2, 1'b1);
        for (int i = 0; i < 10; i++) begin
            checkOutput($sformatf("t6_key%0d", i), {ld_key_valid, ld_key_byte}, {1'b1, key6[255 - 8*i -: 8]});
            ld_key_ready = 1'b1;
            tick();
        end
        ld_key_ready = 1'b0;
        rst_n = 1'b0;
        tick();
        checkResetOutputs("t6_reset");
        rst_n = 1'b1;
        tick();
        checkResetOutputs("t6_release");
        applyStimulus(key7, pt1, 1'b1);
        checkOutput("t6_first_key", ld_key_byte, 8'h77);
        sendKey(key7, 1'b0);
        sendState(pt1);
        finishCore(ct1, 2);
        drainCt(ct1, 99, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
